fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the ROM program memory and the IF/ID pipeline register.
- Owns the fetch PC and drives the ROM address.
- Buffers up to DEPTH fetched instructions, each with its PC+4, so decode can stall without losing fetch bandwidth.
- A redirect from the branch/jump/jr resolution point flushes the queue and restarts fetch at a new PC.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
RESET_PC, 32'h00400000, fetch PC loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  current fetch PC, drives ROM Address
imem_rdata  input  32  ROM instruction at imem_addr; combinational, same cycle
redirect_valid  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch PC (branch, jump, or jr target)
deq_ready  input  1  decode accepts the head entry this cycle (low = stall)
out_valid  output  1  head entry valid
out_instruction  output  32  head instruction, to IF/ID Instruction
out_pc_4  output  32  head PC+4, to IF/ID PC_4
count  output  $clog2(DEPTH)+1  number of valid entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - fetch_pc <= RESET_PC; rd_ptr, wr_ptr, count <= 0.
  - out_valid=0, full=0, empty=1; out_instruction and out_pc_4 read 0.
  - Reset overrides redirect, enqueue and dequeue in the same cycle.
- Storage: circular buffer of DEPTH entries {instruction[31:0], pc_4[31:0]}.
  - Pointers wrap modulo DEPTH.
  - count is a separate register, not derived from pointer difference.
- Outputs:
  - out_valid = (count != 0); out_instruction/out_pc_4 = entry[rd_ptr].
  - These are register-driven, with no combinational path from imem_rdata (unless the optional feature is enabled).
- deq = out_valid & deq_ready & ~redirect_valid.
- enq = ~redirect_valid & (~full | deq).
  - A full queue accepts a new entry in the same cycle the head is dequeued.
- On enq:
  - entry[wr_ptr] <= {imem_rdata, imem_addr + 4}
  - wr_ptr++
  - fetch_pc <= fetch_pc + 4 (32-bit wrap, no saturation)
- On deq: rd_ptr++.
- count update:
  - count += 1 on enq only; count -= 1 on deq only; unchanged on both or neither.
- Redirect (redirect_valid=1, reset=0):
  - All entries discarded: rd_ptr, wr_ptr, count <= 0.
  - fetch_pc <= redirect_pc; no enqueue that cycle.
  - deq_ready is ignored; the head entry is dropped, not delivered.
  - Next cycle: out_valid=0, imem_addr=redirect_pc, fetch resumes.
- Latency:
  - An instruction fetched in cycle N appears at the outputs in cycle N+1 if the queue was empty.
  - Redirect-to-first-valid-output is 2 cycles.
- imem_addr = fetch_pc, combinational from the register.
- Invariants:
  - count never exceeds DEPTH or underflows.
  - Entries leave in fetch order.
  - out_pc_4 of consecutive entries differs by 4 unless a redirect intervened.

Optional Feature:
FETCHQ_BYPASS_EN
- Defined: when empty & ~redirect_valid, the ROM word bypasses storage.
  - out_valid=1, out_instruction=imem_rdata, out_pc_4=imem_addr+4, all combinationally.
  - If deq_ready=1 that cycle, the word is consumed and not written (fetch_pc += 4, count stays 0).
  - If deq_ready=0, it is enqueued normally.
  - Fill latency drops to 0 cycles; redirect-to-first-output drops to 1 cycle.
- Undefined: outputs are purely registered as described above.
- count, full and empty keep the same definitions in both builds.

Test Plan:
- Reset release, deq_ready=1, ROM[i]=i:
  - imem_addr steps 0x00400000, 0x00400004, ...
  - out_valid rises one cycle after reset release.
  - out_instruction 0,1,2,... with out_pc_4 0x00400004, 0x00400008, ...; count stays at most 1.
- deq_ready=0 from reset:
  - After 4 cycles, count=4 and full=1; imem_addr holds at 0x00400010.
  - Head stays instruction 0.
  - Raising deq_ready gives in-order delivery with no loss or duplication.
- Full queue, deq_ready=1 for one cycle:
  - Simultaneous enq/deq; count stays 4.
  - Head advances to entry 1; the newly stored entry has pc_4 0x00400014.
- redirect_valid=1, redirect_pc=0x00400040, with queue holding 3 entries and deq_ready=1:
  - Next cycle: count=0, out_valid=0, imem_addr=0x00400040.
  - Following cycle: out_pc_4=0x00400044.
- reset asserted mid-operation together with redirect_valid and deq_ready:
  - Next cycle: count=0, imem_addr=0x00400000; the redirect is ignored.
- With FETCHQ_BYPASS_EN, after redirect to 0x00400080 and deq_ready=1:
  - In the cycle after redirect, out_valid=1 and out_pc_4=0x00400084 combinationally.
  - count remains 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers ROM words with their PC+4 for decode.
// Optional build macro FETCHQ_BYPASS_EN lets a ROM word reach the outputs directly when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     deq_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_pc_4,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_4;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        fetch_pc;

  entry_t fetched;
  entry_t head;
  logic   head_valid;
  logic   bypass;
  logic   deq;
  logic   enq;
  logic   push;
  logic   pop;

  // Handshake decode; in bypass mode a word consumed straight from the ROM never touches storage.
  always_comb begin
    fetched    = '{instruction: imem_rdata, pc_4: fetch_pc + PC_STEP};
    head       = mem[rd_ptr];
    head_valid = (cnt_q != '0);
    bypass     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass = (cnt_q == '0) & ~redirect_valid;
    if (bypass) begin
      head_valid = 1'b1;
      head       = fetched;
    end
`endif
    deq  = head_valid & deq_ready & ~redirect_valid;
    enq  = ~redirect_valid & (~full | deq);
    push = enq & ~(bypass & deq);
    pop  = deq & ~bypass;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt_q    <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (push) begin
        mem[wr_ptr] <= fetched;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign imem_addr       = fetch_pc;
  assign out_valid       = head_valid;
  assign out_instruction = head.instruction;
  assign out_pc_4        = head.pc_4;
  assign count           = cnt_q;
  assign full            = (cnt_q == CNT_W'(DEPTH));
  assign empty           = (cnt_q == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a fetch/queue model feeds a scoreboard of expected head entries.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00400000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc_4;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_pc;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_pc_4(out_pc_4),
    .count(count), .full(full), .empty(empty)
  );

  // ROM[i] = i, word addressed from RESET_PC
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a - RESET_PC) >> 2;
  endfunction

  assign imem_rdata = rom(imem_addr);

  function automatic logic exp_valid();
    logic v;
    v = (sb.size() != 0);
`ifdef FETCHQ_BYPASS_EN
    if (sb.size() == 0 && !redirect_valid) v = 1'b1;
`endif
    return v;
  endfunction

  function automatic logic [63:0] exp_head();
    if (sb.size() != 0) return sb[0];
    return {rom(m_pc), m_pc + 32'd4};
  endfunction

  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic dr);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    deq_ready      = dr;
    #1;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic step();
    logic d, e;
    if (reset) begin
      m_pc = RESET_PC;
      sb.delete();
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
      sb.delete();
    end
`ifdef FETCHQ_BYPASS_EN
    else if (sb.size() == 0 && deq_ready) begin
      m_pc = m_pc + 32'd4;
    end
`endif
    else begin
      d = (sb.size() != 0) && deq_ready;
      e = (sb.size() < DEPTH) || d;
      if (d) void'(sb.pop_front());
      if (e) begin
        sb.push_back({rom(m_pc), m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_total++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_total++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_total++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
`ifndef FETCHQ_BYPASS_EN
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_total++; if (out_instruction !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", out_instruction); end
    n_total++; if (out_pc_4 !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want 0", out_pc_4); end
    step();
    n_total++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", out_valid); end
    n_total++; if (out_pc_4 !== 32'h00400004) begin n_bad++; $display("FAIL first_pc4: got %h want 00400004", out_pc_4); end
`endif
  endtask

  task automatic test_stream();
    logic [63:0] h;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      h = exp_head();
      n_total++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL stream_addr: got %h want %h", imem_addr, m_pc); end
      n_total++; if (out_valid !== exp_valid()) begin n_bad++; $display("FAIL stream_valid: got %b want %b", out_valid, exp_valid()); end
      if (exp_valid()) begin
        n_total++; if ({out_instruction, out_pc_4} !== h) begin n_bad++; $display("FAIL stream_head: got %h %h want %h", out_instruction, out_pc_4, h); end
      end
      n_total++; if (count > 3'd1) begin n_bad++; $display("FAIL stream_count: got %0d want <=1", count); end
      step();
    end
  endtask

  task automatic test_stall();
    logic [63:0] h;
    logic seen14;
    seen14 = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    n_total++; if (count !== 3'd4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", count); end
    n_total++; if (full !== 1'b1) begin n_bad++; $display("FAIL stall_full: got %b want 1", full); end
    n_total++; if (imem_addr !== 32'h00400010) begin n_bad++; $display("FAIL stall_addr: got %h want 00400010", imem_addr); end
    n_total++; if (out_instruction !== 32'h0) begin n_bad++; $display("FAIL stall_head: got %h want 0", out_instruction); end
    step();
    n_total++; if (imem_addr !== 32'h00400010) begin n_bad++; $display("FAIL stall_hold: got %h want 00400010", imem_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_swap_count: got %0d want 4", count); end
    n_total++; if (out_instruction !== 32'h1) begin n_bad++; $display("FAIL full_swap_head: got %h want 1", out_instruction); end
    n_total++; if (out_pc_4 !== 32'h00400008) begin n_bad++; $display("FAIL full_swap_pc4: got %h want 00400008", out_pc_4); end
    n_total++; if (imem_addr !== 32'h00400014) begin n_bad++; $display("FAIL full_swap_addr: got %h want 00400014", imem_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      h = exp_head();
      if (out_valid && out_pc_4 == 32'h00400014) seen14 = 1'b1;
      n_total++; if ({out_instruction, out_pc_4} !== h) begin n_bad++; $display("FAIL drain_head: got %h %h want %h", out_instruction, out_pc_4, h); end
      n_total++; if (count !== 3'(sb.size())) begin n_bad++; $display("FAIL drain_count: got %0d want %0d", count, sb.size()); end
      step();
    end
    n_total++; if (seen14 !== 1'b1) begin n_bad++; $display("FAIL drain_pc14: got %b want 1", seen14); end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    n_total++; if (count !== 3'd3) begin n_bad++; $display("FAIL redir_pre_count: got %0d want 3", count); end
`ifndef FETCHQ_BYPASS_EN
    drive(1'b0, 1'b1, 32'h00400040, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL redir_count: got %0d want 0", count); end
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid: got %b want 0", out_valid); end
    n_total++; if (imem_addr !== 32'h00400040) begin n_bad++; $display("FAIL redir_addr: got %h want 00400040", imem_addr); end
    step();
    n_total++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL redir_valid2: got %b want 1", out_valid); end
    n_total++; if (out_pc_4 !== 32'h00400044) begin n_bad++; $display("FAIL redir_pc4: got %h want 00400044", out_pc_4); end
    n_total++; if (out_instruction !== 32'h10) begin n_bad++; $display("FAIL redir_instr: got %h want 10", out_instruction); end
`else
    drive(1'b0, 1'b1, 32'h00400080, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL byp_valid: got %b want 1", out_valid); end
    n_total++; if (out_pc_4 !== 32'h00400084) begin n_bad++; $display("FAIL byp_pc4: got %h want 00400084", out_pc_4); end
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL byp_count: got %0d want 0", count); end
    step();
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL byp_count2: got %0d want 0", count); end
    n_total++; if (imem_addr !== 32'h00400088) begin n_bad++; $display("FAIL byp_addr: got %h want 00400088", imem_addr); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    drive(1'b1, 1'b1, 32'h00400080, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    n_total++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rstmid_addr: got %h want %h", imem_addr, RESET_PC); end
    n_total++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty: got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] h;
    logic        rv;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 15) == 0);
      drive(1'b0, rv, RESET_PC + 32'($urandom_range(0, 63)) * 32'd4, 1'($urandom_range(0, 1)));
      h = exp_head();
      n_total++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL b2b_addr: got %h want %h", imem_addr, m_pc); end
      n_total++; if (out_valid !== exp_valid()) begin n_bad++; $display("FAIL b2b_valid: got %b want %b", out_valid, exp_valid()); end
      if (exp_valid()) begin
        n_total++; if ({out_instruction, out_pc_4} !== h) begin n_bad++; $display("FAIL b2b_head: got %h %h want %h", out_instruction, out_pc_4, h); end
      end
      n_total++; if (count !== 3'(sb.size())) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", count, sb.size()); end
      n_total++; if (full !== (sb.size() == DEPTH) || empty !== (sb.size() == 0)) begin
        n_bad++; $display("FAIL b2b_flags: got full=%b empty=%b want count %0d", full, empty, sb.size());
      end
      step();
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    deq_ready      = 1'b0;
    m_pc           = RESET_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
